hmulti_sink: RTL and testbench

Parametrised multi-channel message sink: terminates NCH independent 4-phase req/ack input channels, debounces each request, captures each accepted message, and keeps per-channel statistics. It is the successor to the single-channel null sink, used as the terminal consumer in test benches and on-chip self-test paths. Unlike the null sink, it can optionally check each channel's data against an incrementing sequence and raises a completion flag once every channel has received a programmed number of messages.

---
 rtl/hmulti_sink.sv | 157 +++++++++++++++
 tb/tb_hmulti_sink.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hmulti_sink.sv
// Multi-channel message sink: per-channel debounced 4-phase req/ack
// termination, message capture, saturating counters, optional sequence check
// and an all-channels-complete flag.
//
// Channel FSM states:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | ack low; waiting for req_s held high REQ_CKS cycles (ready=1)
//   ST_ACK  | ack high; waiting for req_s held low REQ_CKS cycles

`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REQ_CKS
`define NS_REQ_CKS 2
`endif

module hmulti_sink #(
   parameter int NCH     = 4,
   parameter int DSZ     = `NS_DATA_SIZE,
   parameter int REQ_CKS = `NS_REQ_CKS,
   parameter int CSZ     = 16,
   parameter int CHECK   = 0,
   parameter int LIMIT   = 0
) (
   input  logic               gch_clk,
   input  logic               gch_reset,
   output logic               gch_ready,
   input  logic [NCH-1:0]     rcv_req,
   output logic [NCH-1:0]     rcv_ack,
   input  logic [NCH*DSZ-1:0] rcv_data,
   output logic [NCH*CSZ-1:0] cnt,
   output logic [NCH*DSZ-1:0] last_data,
   output logic [NCH-1:0]     err,
   output logic               done
);

   // Debounce is a down-counter reloaded to REQ_CKS-1; terminal count 0 with
   // the awaited level present means the level has now held REQ_CKS cycles.
   localparam int             DBW     = (REQ_CKS > 1) ? $clog2(REQ_CKS) : 1;
   localparam logic [DBW-1:0] DB_RLD  = DBW'(REQ_CKS - 1);
   localparam logic [31:0]    LIMIT_U = LIMIT;
   localparam bit             DONE_EN = (LIMIT != 0);
   localparam bit             CHK_EN  = (CHECK != 0);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } ch_state_t;

   logic           ready_q;
   logic [NCH-1:0] req_s_q;
   logic [NCH-1:0] hit;
   logic           done_q, done_d;

   // Ready sets on the first edge after reset release; requests synchronised.
   always_ff @(posedge gch_clk or negedge gch_reset) begin
      if (!gch_reset) begin
         ready_q <= 1'b0;
         req_s_q <= '0;
      end else begin
         ready_q <= 1'b1;
         req_s_q <= rcv_req;
      end
   end

   assign gch_ready = ready_q;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      ch_state_t      st_q, st_d;
      logic [DBW-1:0] db_q, db_d;
      logic [CSZ-1:0] cnt_q, cnt_d;
      logic [DSZ-1:0] last_q, last_d;
      logic [DSZ-1:0] exp_q, exp_d;
      logic           err_q, err_d;
      logic [DSZ-1:0] data_w;
      logic           run;
      logic           fire;

      assign data_w = rcv_data[i*DSZ +: DSZ];

      // Next-state: debounce toward the awaited level, act on terminal count.
      always_comb begin
         st_d   = st_q;
         db_d   = db_q;
         cnt_d  = cnt_q;
         last_d = last_q;
         exp_d  = exp_q;
         err_d  = err_q;
         fire   = 1'b0;
         run    = (st_q == ST_IDLE) ? (req_s_q[i] & ready_q) : ~req_s_q[i];

         if (!run) begin
            db_d = DB_RLD;
         end else if (db_q == '0) begin
            fire = 1'b1;
            db_d = DB_RLD;
         end else begin
            db_d = db_q - DBW'(1);
         end

         if (fire) begin
            case (st_q)
               ST_IDLE: begin
                  st_d   = ST_ACK;
                  last_d = data_w;
                  if (cnt_q != '1) cnt_d = cnt_q + CSZ'(1);
                  if (CHK_EN) begin
                     if (data_w != exp_q) err_d = 1'b1;
                     exp_d = data_w + DSZ'(1);
                  end
               end
               default: st_d = ST_IDLE;
            endcase
         end
      end

      // Channel state registers; reset drops ack and any partial debounce.
      always_ff @(posedge gch_clk or negedge gch_reset) begin
         if (!gch_reset) begin
            st_q   <= ST_IDLE;
            db_q   <= DB_RLD;
            cnt_q  <= '0;
            last_q <= '0;
            exp_q  <= '0;
            err_q  <= 1'b0;
         end else begin
            st_q   <= st_d;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
            exp_q  <= exp_d;
            err_q  <= err_d;
         end
      end

      assign rcv_ack[i]                = (st_q == ST_ACK);
      assign cnt[i*CSZ +: CSZ]         = cnt_q;
      assign last_data[i*DSZ +: DSZ]   = last_q;
      assign err[i]                    = err_q;
      assign hit[i]                    = (32'(cnt_q) >= LIMIT_U);
   end

   // Completion is sticky and lags the last channel's count by one edge.
   always_comb begin
      done_d = done_q | (DONE_EN & (&hit));
   end

   // Completion flag register.
   always_ff @(posedge gch_clk or negedge gch_reset) begin
      if (!gch_reset) done_q <= 1'b0;
      else            done_q <= done_d;
   end

   assign done = done_q;

endmodule

// File: tb/tb_hmulti_sink.sv
// Bench for hmulti_sink: NCH=4, DSZ=8, REQ_CKS=3, CSZ=2, CHECK=1, LIMIT=3.
// Drivers push the expected acceptance record per channel; a monitor pops and
// compares it when that channel's ack rises.

module tb_hmulti_sink;

   localparam int NCH  = 4;
   localparam int DSZ  = 8;
   localparam int R    = 3;
   localparam int CSZ  = 2;
   localparam int LIM  = 3;
   localparam int CMAX = 3;

   typedef struct {
      logic [7:0] data;
      logic [1:0] cnt;
      logic       err;
      int         cyc;
   } msg_t;

   logic               clk;
   logic               rst_n;
   logic               ready;
   logic [NCH-1:0]     req;
   logic [NCH-1:0]     ack;
   logic [NCH*DSZ-1:0] data;
   logic [NCH*CSZ-1:0] cnt;
   logic [NCH*DSZ-1:0] last;
   logic [NCH-1:0]     err;
   logic               done;

   int total;
   int bad;
   int cyc;

   msg_t       sbq[NCH][$];
   int         m_cnt[NCH];
   logic [7:0] m_exp[NCH];
   logic       m_err[NCH];
   int         acc_cnt[NCH];
   logic       m_done;
   logic       done_next;
   logic [NCH-1:0] ack_prev;

   hmulti_sink #(
      .NCH(NCH), .DSZ(DSZ), .REQ_CKS(R), .CSZ(CSZ), .CHECK(1), .LIMIT(LIM)
   ) dut (
      .gch_clk   (clk),
      .gch_reset (rst_n),
      .gch_ready (ready),
      .rcv_req   (req),
      .rcv_ack   (ack),
      .rcv_data  (data),
      .cnt       (cnt),
      .last_data (last),
      .err       (err),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(string tag, logic [63:0] got, logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic clear_model();
      for (int c = 0; c < NCH; c++) begin
         m_cnt[c] = 0;
         m_exp[c] = 8'h00;
         m_err[c] = 1'b0;
         sbq[c].delete();
      end
   endtask

   task automatic push_exp(int c, logic [7:0] d);
      msg_t e;
      if (m_cnt[c] != CMAX) m_cnt[c]++;
      if (d != m_exp[c]) m_err[c] = 1'b1;
      m_exp[c] = d + 8'd1;
      e.data = d;
      e.cnt  = 2'(m_cnt[c]);
      e.err  = m_err[c];
      e.cyc  = cyc + 1 + R;
      sbq[c].push_back(e);
   endtask

   task automatic wait_ack(int c, logic v, int budget);
      int n;
      n = 0;
      while (ack[c] !== v && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (ack[c] !== v) check_val("ack_timeout", {63'd0, ack[c]}, {63'd0, v});
   endtask

   task automatic send(int c, logic [7:0] d);
      int t0;
      @(negedge clk);
      data[c*DSZ +: DSZ] = d;
      req[c] = 1'b1;
      push_exp(c, d);
      wait_ack(c, 1'b1, 40);
      req[c] = 1'b0;
      t0 = cyc;
      wait_ack(c, 1'b0, 40);
      check_val("ack_fall_cyc", cyc, t0 + 1 + R);
   endtask

   task automatic do_reset();
      int left;
      left = 0;
      for (int c = 0; c < NCH; c++) left += sbq[c].size();
      check_val("sb_left", left, 0);
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      data  = '0;
      clear_model();
      repeat (5) @(negedge clk);
      check_val("rst_outs", {ready, ack, cnt, last, err, done}, 64'd0);
      rst_n = 1'b1;
      #1 check_val("ready_pre", ready, 1'b0);
      @(negedge clk);
      check_val("ready", ready, 1'b1);
   endtask

   task automatic monitor();
      msg_t e;
      logic any;
      logic all;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            for (int c = 0; c < NCH; c++) acc_cnt[c] = 0;
            m_done    = 1'b0;
            done_next = 1'b0;
         end else begin
            if (done_next) begin
               check_val("done_rise", done, 1'b1);
               done_next = 1'b0;
            end
            any = 1'b0;
            for (int c = 0; c < NCH; c++) begin
               if (ack[c] && !ack_prev[c]) begin
                  any = 1'b1;
                  if (sbq[c].size() == 0) begin
                     check_val("spurious_ack", ack[c], 1'b0);
                  end else begin
                     e = sbq[c].pop_front();
                     check_val("ack_rise_cyc", cyc, e.cyc);
                     check_val("last_data", last[c*DSZ +: DSZ], e.data);
                     check_val("cnt", cnt[c*CSZ +: CSZ], e.cnt);
                     check_val("err", err[c], e.err);
                     acc_cnt[c] = e.cnt;
                  end
               end
            end
            if (any) begin
               check_val("done_level", done, m_done);
               if (!m_done) begin
                  all = 1'b1;
                  for (int c = 0; c < NCH; c++) if (acc_cnt[c] < LIM) all = 1'b0;
                  if (all) begin
                     m_done    = 1'b1;
                     done_next = 1'b1;
                  end
               end
            end
         end
         ack_prev = ack;
      end
   endtask

   task automatic run_ch(int c);
      for (int k = 0; k < 5; k++) begin
         repeat (c * 3) @(negedge clk);
         send(c, 8'(k));
      end
   endtask

   initial begin
      int t0;
      total     = 0;
      bad       = 0;
      cyc       = 0;
      rst_n     = 1'b0;
      req       = '0;
      data      = '0;
      ack_prev  = '0;
      m_done    = 1'b0;
      done_next = 1'b0;
      for (int c = 0; c < NCH; c++) acc_cnt[c] = 0;
      clear_model();

      fork
         monitor();
         begin
            #200000;
            $display("FAIL watchdog: got timeout want completion");
            $fatal(1, "watchdog");
         end
      join_none

      // Reset and ready.
      do_reset();

      // Single message on channel 2.
      send(2, 8'h5A);
      check_val("other_cnt", {cnt[7:6], cnt[3:0]}, 0);
      check_val("other_last", {last[31:24], last[15:0]}, 0);
      check_val("other_ack", {ack[3], ack[1:0]}, 0);

      // Short high pulse in IDLE is ignored.
      do_reset();
      @(negedge clk);
      req[0] = 1'b1;
      repeat (2) @(negedge clk);
      req[0] = 1'b0;
      repeat (10) @(negedge clk);
      check_val("pulse_ack", ack[0], 1'b0);
      check_val("pulse_cnt", cnt[1:0], 2'd0);

      // Short low glitch in ACK is ignored.
      @(negedge clk);
      data[7:0] = 8'h00;
      req[0] = 1'b1;
      push_exp(0, 8'h00);
      wait_ack(0, 1'b1, 40);
      req[0] = 1'b0;
      repeat (2) @(negedge clk);
      req[0] = 1'b1;
      repeat (8) @(negedge clk);
      check_val("glitch_ack", ack[0], 1'b1);
      check_val("glitch_cnt", cnt[1:0], 2'd1);
      req[0] = 1'b0;
      t0 = cyc;
      wait_ack(0, 1'b0, 40);
      check_val("glitch_fall_cyc", cyc, t0 + 1 + R);

      // Sequence check: gap on channel 1, clean count on channel 3.
      do_reset();
      fork
         begin
            send(1, 8'd0);
            send(1, 8'd1);
            send(1, 8'd2);
            send(1, 8'd4);
            send(1, 8'd5);
         end
         begin
            for (int k = 0; k < 8; k++) send(3, 8'(k));
         end
      join
      check_val("err1_sticky", err[1], 1'b1);
      check_val("err3_clean", err[3], 1'b0);

      // Done and saturation with all channels concurrent.
      do_reset();
      fork
         run_ch(0);
         run_ch(1);
         run_ch(2);
         run_ch(3);
      join
      @(negedge clk);
      check_val("sat_cnt", cnt, 8'hFF);
      check_val("done_hold", done, 1'b1);
      check_val("err_none", err, 4'h0);

      // Asynchronous reset while channel 1 is acknowledged.
      do_reset();
      @(negedge clk);
      data[15:8] = 8'h00;
      req[1] = 1'b1;
      push_exp(1, 8'h00);
      wait_ack(1, 1'b1, 40);
      #2 rst_n = 1'b0;
      #1;
      check_val("async_ack", ack[1], 1'b0);
      check_val("async_cnt", cnt, 8'h00);
      check_val("async_done", done, 1'b0);
      check_val("async_ready", ready, 1'b0);
      clear_model();
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      push_exp(1, 8'h00);
      wait_ack(1, 1'b1, 40);
      check_val("reaccept_cnt", cnt[3:2], 2'd1);
      req[1] = 1'b0;
      t0 = cyc;
      wait_ack(1, 1'b0, 40);
      check_val("reaccept_fall_cyc", cyc, t0 + 1 + R);
      repeat (2) @(negedge clk);
      t0 = 0;
      for (int c = 0; c < NCH; c++) t0 += sbq[c].size();
      check_val("sb_left_end", t0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
